// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the ALU/MDU block: op-codes, FSM state type and
// the default datapath width.
package alu_mdu_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [4:0] OP_ADDU    = 5'd0;
   localparam logic [4:0] OP_SUBU    = 5'd1;
   localparam logic [4:0] OP_ADD     = 5'd2;
   localparam logic [4:0] OP_SUB     = 5'd3;
   localparam logic [4:0] OP_AND     = 5'd4;
   localparam logic [4:0] OP_OR      = 5'd5;
   localparam logic [4:0] OP_XOR     = 5'd6;
   localparam logic [4:0] OP_NOR     = 5'd7;
   localparam logic [4:0] OP_LUI     = 5'd8;
   localparam logic [4:0] OP_LUI_ALT = 5'd9;
   localparam logic [4:0] OP_SLTU    = 5'd10;
   localparam logic [4:0] OP_SLT     = 5'd11;
   localparam logic [4:0] OP_SRA     = 5'd12;
   localparam logic [4:0] OP_SRL     = 5'd13;
   localparam logic [4:0] OP_SLL     = 5'd14;
   localparam logic [4:0] OP_SLL_ALT = 5'd15;
   localparam logic [4:0] OP_MULT    = 5'd16;
   localparam logic [4:0] OP_MULTU   = 5'd17;
   localparam logic [4:0] OP_DIV     = 5'd18;
   localparam logic [4:0] OP_DIVU    = 5'd19;
   localparam logic [4:0] OP_MFHI    = 5'd20;
   localparam logic [4:0] OP_MFLO    = 5'd21;
   localparam logic [4:0] OP_MTHI    = 5'd22;
   localparam logic [4:0] OP_MTLO    = 5'd23;

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;

endpackage

// File: rtl/alu_mdu_div.sv
// Iterative restoring divider: one quotient bit per step on operand magnitudes,
// sign fix-up and divide-by-zero / overflow handling applied on the outputs.
module alu_mdu_div
   import alu_mdu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             step_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] quo_o,
   output logic [WIDTH-1:0] rem_o,
   output logic             ovf_o
);

   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, a_q, a_d;
   logic             sq_q, sq_d, sr_q, sr_d, dz_q, dz_d, ovf_q, ovf_d;
   logic [WIDTH:0]   rem_sh, rem_sub;
   logic [WIDTH-1:0] quo_n, rem_n;
   logic             ge, a_neg, b_neg;

   always_comb begin
      a_neg   = signed_i & a_i[WIDTH-1];
      b_neg   = signed_i & b_i[WIDTH-1];
      rem_sh  = {rem_q, quo_q[WIDTH-1]};
      rem_sub = rem_sh - {1'b0, dvs_q};
      ge      = (rem_sh >= {1'b0, dvs_q});
      rem_n   = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo_n   = {quo_q[WIDTH-2:0], ge};

      quo_d = quo_q;
      rem_d = rem_q;
      dvs_d = dvs_q;
      a_d   = a_q;
      sq_d  = sq_q;
      sr_d  = sr_q;
      dz_d  = dz_q;
      ovf_d = ovf_q;
      if (start_i) begin
         quo_d = a_neg ? -a_i : a_i;
         rem_d = '0;
         dvs_d = b_neg ? -b_i : b_i;
         a_d   = a_i;
         sq_d  = a_neg ^ b_neg;
         sr_d  = a_neg;
         dz_d  = (b_i == '0);
         ovf_d = (b_i == '0) |
                 (signed_i & (a_i == {1'b1, {(WIDTH-1){1'b0}}}) & (b_i == '1));
      end else if (step_i) begin
         quo_d = quo_n;
         rem_d = rem_n;
      end
   end

   // Outputs reflect the state after the current step, so the final step's
   // result is available on the same edge the controller leaves DIV.
   always_comb begin
      quo_o = dz_q ? '1  : (sq_q ? -quo_n : quo_n);
      rem_o = dz_q ? a_q : (sr_q ? -rem_n : rem_n);
      ovf_o = ovf_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         a_q   <= '0;
         sq_q  <= 1'b0;
         sr_q  <= 1'b0;
         dz_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         a_q   <= a_d;
         sq_q  <= sq_d;
         sr_q  <= sr_d;
         dz_q  <= dz_d;
         ovf_q <= ovf_d;
      end
   end

endmodule

// File: rtl/alu_mdu.sv
// ALU with MIPS-style multiply/divide unit and HI/LO registers.
// Define ALU_MDU_DIV_EN to build the iterative divider; otherwise DIV/DIVU report overflow.
//
// state | meaning
// IDLE  | ready for a request
// MUL   | shift-add multiply, WIDTH iterations
// DIV   | restoring divide, WIDTH iterations
// DONE  | result held until out_ready
module alu_mdu
   import alu_mdu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic             zero,
   output logic             carry,
   output logic             negative,
   output logic             overflow,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int SHW = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]   r_q, r_d, hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d, prod_step, prod_fix;
   logic               mneg_q, mneg_d;
   logic               z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;
   logic               accept, last_iter, msigned;
   logic [WIDTH-1:0]   alu_r, a_mag, b_mag;
   logic               alu_c, alu_v;
   logic [WIDTH:0]     sum_u, dif_u, acc;
   logic [SHW-1:0]     shamt, ridx, lidx;

   assign in_ready  = (state_q == ST_IDLE) && !rst;
   assign accept    = in_valid && in_ready;
   assign last_iter = (cnt_q == SHW'(WIDTH-1));

`ifdef ALU_MDU_DIV_EN
   logic [WIDTH-1:0] div_quo, div_rem;
   logic             div_ovf;

   alu_mdu_div #(.WIDTH(WIDTH)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start_i  (accept && (op == OP_DIV || op == OP_DIVU)),
      .step_i   (state_q == ST_DIV),
      .signed_i (op == OP_DIV),
      .a_i      (a),
      .b_i      (b),
      .quo_o    (div_quo),
      .rem_o    (div_rem),
      .ovf_o    (div_ovf)
   );
`endif

   always_comb begin
      alu_r = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      shamt = a[SHW-1:0];
      ridx  = shamt - SHW'(1);
      lidx  = SHW'(0) - shamt;
      sum_u = {1'b0, a} + {1'b0, b};
      dif_u = {1'b0, a} - {1'b0, b};
      case (op)
         OP_SUBU: begin
            alu_r = dif_u[WIDTH-1:0];
            alu_c = dif_u[WIDTH];
         end
         OP_ADD: begin
            alu_r = sum_u[WIDTH-1:0];
            alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_r = dif_u[WIDTH-1:0];
            alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:             alu_r = a & b;
         OP_OR:              alu_r = a | b;
         OP_XOR:             alu_r = a ^ b;
         OP_NOR:             alu_r = ~(a | b);
         OP_LUI, OP_LUI_ALT: alu_r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         OP_SLTU: begin
            alu_r = {{(WIDTH-1){1'b0}}, dif_u[WIDTH]};
            alu_c = dif_u[WIDTH];
         end
         OP_SLT: alu_r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SRA: begin
            alu_r = $signed(b) >>> shamt;
            alu_c = (shamt != '0) & b[ridx];
         end
         OP_SRL: begin
            alu_r = b >> shamt;
            alu_c = (shamt != '0) & b[ridx];
         end
         OP_SLL, OP_SLL_ALT: begin
            alu_r = b << shamt;
            alu_c = (shamt != '0) & b[lidx];
         end
         OP_MULT, OP_MULTU: alu_r = '0;
`ifdef ALU_MDU_DIV_EN
         OP_DIV, OP_DIVU:   alu_r = '0;
`else
         OP_DIV, OP_DIVU:   alu_v = 1'b1;
`endif
         OP_MFHI: alu_r = hi_q;
         OP_MFLO: alu_r = lo_q;
         OP_MTHI, OP_MTLO: alu_r = a;
         default: begin
            alu_r = sum_u[WIDTH-1:0];
            alu_c = sum_u[WIDTH];
         end
      endcase
   end

   // Multiply on magnitudes; the sign is re-applied once at the end.
   always_comb begin
      msigned   = (op == OP_MULT);
      a_mag     = (msigned & a[WIDTH-1]) ? -a : a;
      b_mag     = (msigned & b[WIDTH-1]) ? -b : b;
      acc       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      prod_step = {acc, prod_q[WIDTH-1:1]};
      prod_fix  = mneg_q ? -prod_step : prod_step;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      z_d     = z_q;
      c_d     = c_q;
      n_d     = n_q;
      v_d     = v_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      mneg_d  = mneg_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               r_d     = alu_r;
               z_d     = (alu_r == '0);
               c_d     = alu_c;
               n_d     = alu_r[WIDTH-1];
               v_d     = alu_v;
               cnt_d   = '0;
               state_d = ST_DONE;
               case (op)
                  OP_MULT, OP_MULTU: begin
                     state_d = ST_MUL;
                     mcand_d = b_mag;
                     prod_d  = {{WIDTH{1'b0}}, a_mag};
                     mneg_d  = msigned & (a[WIDTH-1] ^ b[WIDTH-1]);
                  end
`ifdef ALU_MDU_DIV_EN
                  OP_DIV, OP_DIVU: state_d = ST_DIV;
`endif
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         ST_MUL: begin
            prod_d = prod_step;
            cnt_d  = cnt_q + SHW'(1);
            if (last_iter) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               hi_d    = prod_fix[2*WIDTH-1:WIDTH];
               lo_d    = prod_fix[WIDTH-1:0];
            end
         end
         ST_DIV: begin
`ifdef ALU_MDU_DIV_EN
            cnt_d = cnt_q + SHW'(1);
            if (last_iter) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               hi_d    = div_rem;
               lo_d    = div_quo;
               v_d     = div_ovf;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         n_q     <= 1'b0;
         v_q     <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         mneg_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         z_q     <= z_d;
         c_q     <= c_d;
         n_q     <= n_d;
         v_q     <= v_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         mneg_q  <= mneg_d;
      end
   end

   assign out_valid = (state_q == ST_DONE);
   assign r         = r_q;
   assign zero      = z_q;
   assign carry     = c_q;
   assign negative  = n_q;
   assign overflow  = v_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Randomized bench for alu_mdu (WIDTH=32) against an arithmetic reference model.
module tb_alu_mdu;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_ready, out_valid, out_ready;
   logic          zero, carry, negative, overflow;
   logic [4:0]    op;
   logic [W-1:0]  a, b, r, hi, lo;
   int            checks = 0;
   int            failures = 0;
   logic [31:0]   m_hi, m_lo;

   always #5 clk = ~clk;

   alu_mdu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .r         (r),
      .zero      (zero),
      .carry     (carry),
      .negative  (negative),
      .overflow  (overflow),
      .hi        (hi),
      .lo        (lo)
   );

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: result, carry, overflow, latency; updates model HI/LO.
   task automatic ref_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] er, output logic ec, output logic ev,
                         output int elat);
      logic [63:0] t;
      longint      s;
      int          amt;
      er = '0; ec = 1'b0; ev = 1'b0; elat = 1; amt = int'(x[4:0]);
      case (o)
         5'd1: begin er = x - y; ec = (x < y); end
         5'd2: begin
            s  = longint'($signed(x)) + longint'($signed(y));
            er = s[31:0];
            ev = (s != longint'($signed(er)));
         end
         5'd3: begin
            s  = longint'($signed(x)) - longint'($signed(y));
            er = s[31:0];
            ev = (s != longint'($signed(er)));
         end
         5'd4: er = x & y;
         5'd5: er = x | y;
         5'd6: er = x ^ y;
         5'd7: er = ~(x | y);
         5'd8, 5'd9: er = {y[15:0], 16'h0000};
         5'd10: begin er = {31'd0, (x < y)}; ec = (x < y); end
         5'd11: er = {31'd0, ($signed(x) < $signed(y))};
         5'd12: begin t = $signed({y, 32'h0}) >>> amt; er = t[63:32]; ec = t[31]; end
         5'd13: begin t = {y, 32'h0} >> amt;           er = t[63:32]; ec = t[31]; end
         5'd14, 5'd15: begin t = {32'h0, y} << amt;   er = t[31:0];  ec = t[32]; end
         5'd16: begin
            t = longint'($signed(x)) * longint'($signed(y));
            m_hi = t[63:32]; m_lo = t[31:0]; elat = W + 1;
         end
         5'd17: begin
            t = {32'h0, x} * {32'h0, y};
            m_hi = t[63:32]; m_lo = t[31:0]; elat = W + 1;
         end
         5'd18, 5'd19: begin
`ifdef ALU_MDU_DIV_EN
            elat = W + 1;
            if (y == 32'h0) begin
               m_lo = 32'hFFFFFFFF; m_hi = x; ev = 1'b1;
            end else if (o == 5'd18 && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
               m_lo = x; m_hi = 32'h0; ev = 1'b1;
            end else if (o == 5'd18) begin
               m_lo = $signed(x) / $signed(y);
               m_hi = $signed(x) % $signed(y);
            end else begin
               m_lo = x / y;
               m_hi = x % y;
            end
`else
            ev = 1'b1;
`endif
         end
         5'd20: er = m_hi;
         5'd21: er = m_lo;
         5'd22: begin m_hi = x; er = x; end
         5'd23: begin m_lo = x; er = x; end
         default: {ec, er} = {1'b0, x} + {1'b0, y};
      endcase
   endtask

   task automatic do_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int hold, input string tag);
      logic [31:0] er;
      logic        ec, ev;
      int          elat, lat, waitc;
      ref_op(o, x, y, er, ec, ev, elat);
      op = o; a = x; b = y; in_valid = 1'b1;
      waitc = 0;
      while (!in_ready && waitc < 50) begin
         @(posedge clk); #1; waitc++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      chk_eq({tag, ":lat"}, 64'(lat), 64'(elat));
      chk_eq({tag, ":r"},   r, er);
      chk_eq({tag, ":z"},   zero, (er == 32'h0));
      chk_eq({tag, ":c"},   carry, ec);
      chk_eq({tag, ":n"},   negative, er[31]);
      chk_eq({tag, ":v"},   overflow, ev);
      chk_eq({tag, ":hi"},  hi, m_hi);
      chk_eq({tag, ":lo"},  lo, m_lo);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk_eq({tag, ":hold_r"},   r, er);
         chk_eq({tag, ":hold_ov"},  out_valid, 1'b1);
         chk_eq({tag, ":hold_rdy"}, in_ready, 1'b0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [4:0]  ro;
      logic [31:0] rx, ry;
      int          sel, seen;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
      m_hi = '0; m_lo = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst:rdy", in_ready, 1'b0);
      chk_eq("rst:ov",  out_valid, 1'b0);
      chk_eq("rst:r",   r, 32'h0);
      chk_eq("rst:flags", {zero, carry, negative, overflow}, 4'h0);
      chk_eq("rst:hi",  hi, 32'h0);
      chk_eq("rst:lo",  lo, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk_eq("rst:rdy_after", in_ready, 1'b1);

      do_op(5'd2,  32'h7FFFFFFF, 32'h1, 0, "add_ovf");
      do_op(5'd16, 32'hFFFFFFFE, 32'h3, 0, "mult_neg");
      chk_eq("mult_neg:hi_k", hi, 32'hFFFFFFFF);
      chk_eq("mult_neg:lo_k", lo, 32'hFFFFFFFA);
      do_op(5'd18, 32'hFFFFFFF9, 32'h2, 0, "div_neg");
      do_op(5'd19, 32'h7,        32'h0, 0, "divu_zero");
      do_op(5'd18, 32'h80000000, 32'hFFFFFFFF, 0, "div_min");
      do_op(5'd12, 32'h4, 32'h80000018, 5, "sra_hold");
      do_op(5'd14, 32'h0,  32'h80000001, 0, "sll_zero_amt");
      do_op(5'd13, 32'h1F, 32'h80000000, 0, "srl_31");
      do_op(5'd14, 32'h1,  32'h80000000, 0, "sll_out");
      do_op(5'd1,  32'h1,  32'h2, 0, "subu_borrow");
      do_op(5'd3,  32'h80000000, 32'h1, 0, "sub_ovf");
      do_op(5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "multu_max");
      do_op(5'd22, 32'h12345678, 32'h0, 0, "mthi");
      do_op(5'd20, 32'h0, 32'h0, 0, "mfhi");
      do_op(5'd8,  32'h0, 32'hABCD1234, 0, "lui");
      do_op(5'd27, 32'hFFFFFFFF, 32'h1, 0, "op27_addu");

      // Reset during a MULTU must abort it and clear HI/LO.
      op = 5'd17; a = 32'hDEADBEEF; b = 32'h12345678; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk_eq("rstmul:rdy_in_rst", in_ready, 1'b0);
      rst = 1'b0;
      m_hi = '0; m_lo = '0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen++;
         @(posedge clk); #1;
      end
      chk_eq("rstmul:ov_seen", 64'(seen), 64'd0);
      chk_eq("rstmul:hi", hi, 32'h0);
      chk_eq("rstmul:lo", lo, 32'h0);
      chk_eq("rstmul:rdy", in_ready, 1'b1);
      do_op(5'd21, 32'h5, 32'h6, 0, "mflo_after_rst");

      for (int n = 0; n < 60; n++) begin
         ro  = 5'($urandom_range(0, 31));
         rx  = $urandom;
         ry  = $urandom;
         sel = $urandom_range(0, 7);
         case (sel)
            0: ry = 32'h0;
            1: begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
            2: rx = 32'($urandom_range(0, 40));
            3: ry = 32'($urandom_range(1, 9));
            default: ;
         endcase
         do_op(ro, rx, ry, $urandom_range(0, 2), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
